// File: rtl/glm_seq_pkg.sv
// glm_seq_pkg: shared state encoding, instruction field layout and decoded instruction type
package glm_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_INSTR,
      S_DISPATCH,
      S_WAIT_DONE,
      S_FINISH
   } t_seqstate;
   localparam int SEQ_UNIT_HI = 167;
   localparam int SEQ_UNIT_LO = 160;
   localparam int SEQ_LAST_BIT = 168;
   localparam int SEQ_JCOUNT_HI = 184;
   localparam int SEQ_JCOUNT_LO = 169;
   localparam int SEQ_JTARGET_HI = 190;
   localparam int SEQ_JTARGET_LO = 185;
   localparam int SEQ_RSVD_BIT = 191;
   localparam logic [7:0] SEQ_UNIT_JUMP = 8'hFF;
   typedef struct packed {
      logic         rsvd;
      logic [5:0]   jtarget;
      logic [15:0]  jcount;
      logic         last;
      logic [7:0]   unit;
      logic [159:0] regs;
   } t_instruction;
endpackage

// File: rtl/glm_seq_decode.sv
// glm_seq_decode: unpacks an instruction word and classifies it as op, jump or invalid
module glm_seq_decode
   import glm_seq_pkg::*;
#(
   parameter int NUM_OPS = 4
) (
   input  logic [191:0]  word,
   output t_instruction  instr,
   output logic          is_jump,
   output logic          is_valid,
   output logic          is_invalid
);
   always_comb begin
      instr.rsvd    = word[SEQ_RSVD_BIT];
      instr.jtarget = word[SEQ_JTARGET_HI:SEQ_JTARGET_LO];
      instr.jcount  = word[SEQ_JCOUNT_HI:SEQ_JCOUNT_LO];
      instr.last    = word[SEQ_LAST_BIT];
      instr.unit    = word[SEQ_UNIT_HI:SEQ_UNIT_LO];
      instr.regs    = word[SEQ_UNIT_LO-1:0];
   end
   assign is_jump    = instr.unit == SEQ_UNIT_JUMP;
   assign is_valid   = !is_jump && 32'(instr.unit) < NUM_OPS;
   assign is_invalid = !is_jump && !is_valid;
endmodule

// File: rtl/glm_op_sequencer.sv
// glm_op_sequencer: fetches instructions, dispatches them to operator units and runs one counted loop level
module glm_op_sequencer
   import glm_seq_pkg::*;
#(
   parameter int NUM_OPS         = 4,
   parameter int NUM_REGS        = 5,
   parameter int LOG2_PROG_DEPTH = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LOG2_PROG_DEPTH:0]   prog_length,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic                       instr_re,
   output logic [LOG2_PROG_DEPTH-1:0] instr_raddr,
   input  logic                       instr_rvalid,
   input  logic [191:0]               instr_rdata,
   output logic [NUM_OPS-1:0]         op_start,
   output logic [NUM_REGS*32-1:0]     regs,
   input  logic [NUM_OPS-1:0]         op_done,
   output logic [47:0]                cycle_count
);
   localparam int PW = LOG2_PROG_DEPTH + 1;
   t_seqstate state, state_nx;
   t_instruction instr;
   logic [PW-1:0] pc, pc_nx, len;
   logic [15:0] loop_cnt;
   logic [191:0] word;
   logic [NUM_OPS-1:0] sel;
   logic is_jump, is_valid, is_invalid, take, got_done, step, fin;
   glm_seq_decode #(.NUM_OPS(NUM_OPS)) u_decode (
      .word       (word),
      .instr      (instr),
      .is_jump    (is_jump),
      .is_valid   (is_valid),
      .is_invalid (is_invalid)
   );
   assign busy        = state != S_IDLE;
   assign done        = state == S_FINISH;
   assign instr_re    = state == S_FETCH;
   assign instr_raddr = pc[LOG2_PROG_DEPTH-1:0];
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else state <= state_nx;
   end
   always_comb begin
      take     = is_jump && loop_cnt < instr.jcount;
      pc_nx    = take ? PW'(instr.jtarget) : pc + 1'b1;
      got_done = |(op_done & sel) && ~|op_start;
      step     = (state == S_DISPATCH && is_jump) || (state == S_WAIT_DONE && got_done);
      fin      = (instr.last && !take) || pc_nx >= len;
      state_nx = state;
      case (state)
         S_IDLE:       if (start) state_nx = ~|prog_length ? S_FINISH : S_FETCH;
         S_FETCH:      state_nx = S_WAIT_INSTR;
         S_WAIT_INSTR: if (instr_rvalid) state_nx = S_DISPATCH;
         S_DISPATCH:   state_nx = is_valid ? S_WAIT_DONE : (is_invalid || fin) ? S_FINISH : S_FETCH;
         S_WAIT_DONE:  if (got_done) state_nx = fin ? S_FINISH : S_FETCH;
         S_FINISH:     state_nx = S_IDLE;
         default:      state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= '0;
         len         <= '0;
         loop_cnt    <= '0;
         word        <= '0;
         sel         <= '0;
         op_start    <= '0;
         regs        <= '0;
         error       <= 1'b0;
         cycle_count <= '0;
      end else begin
         op_start <= '0;
         if (state == S_IDLE && start) begin
            pc          <= '0;
            loop_cnt    <= '0;
            cycle_count <= '0;
            error       <= 1'b0;
            len         <= prog_length;
         end else if (busy && ~&cycle_count) begin
            cycle_count <= cycle_count + 1'b1;
         end
         if (state == S_WAIT_INSTR && instr_rvalid) word <= instr_rdata;
         if (state == S_DISPATCH && is_valid) begin
            regs     <= (NUM_REGS*32)'(instr.regs);
            op_start <= NUM_OPS'(1) << instr.unit;
            sel      <= NUM_OPS'(1) << instr.unit;
         end
         if (state == S_DISPATCH && is_invalid) error <= 1'b1;
         if (state == S_DISPATCH && is_jump) loop_cnt <= take ? loop_cnt + 1'b1 : '0;
         if (step) pc <= pc_nx;
      end
   end
endmodule
